// File: rtl/uart_hex_loader_if.sv
// Signal bundle between a character source/SRAM and the hex loader.
// The slave modport is the loader; the master modport is whatever drives it.
interface uart_hex_loader_if;
   logic       start;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       recv_error;
   logic       sram_en;
   logic       sram_we;
   logic [10:0] sram_addr;
   logic [7:0] sram_wdata;
   logic       busy;
   logic       done;
   logic       err;
   logic [5:0] byte_count;

   modport master (
      output start, rx_valid, rx_byte, recv_error,
      input  sram_en, sram_we, sram_addr, sram_wdata, busy, done, err, byte_count
   );

   modport slave (
      input  start, rx_valid, rx_byte, recv_error,
      output sram_en, sram_we, sram_addr, sram_wdata, busy, done, err, byte_count
   );
endinterface

// File: rtl/uart_hex_loader.sv
// Turns a UART stream of ASCII hex digit pairs into NUM_BYTES consecutive
// SRAM writes starting at BASE_ADDR; separators are skipped, anything else flags err.
module uart_hex_loader #(
   parameter int NUM_BYTES = 32,
   parameter int BASE_ADDR = 2
) (
   input  logic             clk,
   input  logic             rst,
   uart_hex_loader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, WRITE, FIN} state_t;

   localparam logic [5:0]  LAST_COUNT = 6'(NUM_BYTES - 1);
   localparam logic [10:0] BASE       = 11'(BASE_ADDR);

   state_t      state, state_nx;
   logic [3:0]  hi_nib, nib;
   logic        is_hex, is_sep, rx_ok;
   logic        latch_hi, load_wr, set_err, clear_frame, inc_count;
   logic [10:0] addr_q;
   logic [7:0]  wdata_q;
   logic [5:0]  count_q;
   logic        err_q;

   // Character classification; letters map to 10..15 via low nibble + 9.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      nib    = 4'h0;
      is_hex = 1'b1;
      if (bus.rx_byte inside {[8'h30:8'h39]})
         nib = bus.rx_byte[3:0];
      else if (bus.rx_byte inside {[8'h41:8'h46], [8'h61:8'h66]})
         nib = bus.rx_byte[3:0] + 4'd9;
      else
         is_hex = 1'b0;
      is_sep = bus.rx_byte inside {8'h20, 8'h2C, 8'h0D, 8'h0A, 8'h5B, 8'h5D};
   end

   // A framing error poisons the character that arrives with it.
   assign rx_ok = bus.rx_valid & ~bus.recv_error;

   always_comb begin
      state_nx    = state;
      latch_hi    = 1'b0;
      load_wr     = 1'b0;
      set_err     = 1'b0;
      clear_frame = 1'b0;
      inc_count   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx    = WAIT_HI;
               clear_frame = 1'b1;
            end
         end
         WAIT_HI: begin
            set_err = bus.recv_error;
            if (rx_ok) begin
               if (is_hex) begin
                  latch_hi = 1'b1;
                  state_nx = WAIT_LO;
               end else if (!is_sep) begin
                  set_err = 1'b1;
               end
            end
         end
         WAIT_LO: begin
            set_err = bus.recv_error;
            if (rx_ok) begin
               if (is_hex) begin
                  load_wr  = 1'b1;
                  state_nx = WRITE;
               end else begin
                  set_err  = 1'b1;
                  state_nx = WAIT_HI;
               end
            end
         end
         WRITE: begin
            // Any character landing here is an overrun and is dropped.
            set_err   = bus.recv_error | bus.rx_valid;
            inc_count = 1'b1;
            state_nx  = (count_q == LAST_COUNT) ? FIN : WAIT_HI;
         end
         FIN: begin
            set_err  = bus.recv_error;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_nib  <= 4'h0;
         addr_q  <= 11'h000;
         wdata_q <= 8'h00;
         count_q <= 6'd0;
         err_q   <= 1'b0;
      end else begin
         if (clear_frame) begin
            count_q <= 6'd0;
            err_q   <= 1'b0;
         end
         if (set_err)   err_q   <= 1'b1;
         if (latch_hi)  hi_nib  <= nib;
         if (load_wr) begin
            addr_q  <= BASE + 11'(count_q);
            wdata_q <= {hi_nib, nib};
         end
         if (inc_count) count_q <= count_q + 6'd1;
      end
   end

   assign bus.sram_en    = (state == WRITE);
   assign bus.sram_we    = (state == WRITE);
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = wdata_q;
   assign bus.busy       = (state == WAIT_HI) || (state == WAIT_LO) || (state == WRITE);
   assign bus.done       = (state == FIN);
   assign bus.err        = err_q;
   assign bus.byte_count = count_q;
endmodule

// File: tb/tb_uart_hex_loader.sv
// Drives two loaders (2-byte and 8-byte frames) with identical character streams and
// compares them each cycle against a behavioural model, plus directed literal checks.
module tb_uart_hex_loader;
   localparam int BASE = 2;
   localparam int NB0  = 2;
   localparam int NB1  = 8;
   localparam int P_IDLE = 0, P_HI = 1, P_LO = 2, P_WR = 3, P_FIN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_start = 1'b0, s_rxv = 1'b0, s_rerr = 1'b0;
   logic [7:0] s_rxb = 8'h00;

   always #5 clk = ~clk;

   uart_hex_loader_if bus0 ();
   uart_hex_loader_if bus1 ();

   assign bus0.start = s_start;  assign bus0.rx_valid = s_rxv;
   assign bus0.rx_byte = s_rxb;  assign bus0.recv_error = s_rerr;
   assign bus1.start = s_start;  assign bus1.rx_valid = s_rxv;
   assign bus1.rx_byte = s_rxb;  assign bus1.recv_error = s_rerr;

   uart_hex_loader #(.NUM_BYTES(NB0), .BASE_ADDR(BASE)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   uart_hex_loader #(.NUM_BYTES(NB1), .BASE_ADDR(BASE)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int  checks = 0, failures = 0, cyc = 0;
   bit  chk_on = 1'b0;

   // Behavioural model: one entry per instance.
   int         nb [2] = '{NB0, NB1};
   int         m_ph [2], m_hi [2], m_cnt [2], m_addr [2], m_wd [2];
   bit         m_err [2];
   logic [7:0] m_mem [2][2048];
   logic [7:0] obs_mem [2][2048];

   logic [18:0] wlog0 [$], wlog1 [$];
   int          wcyc0 [$];
   int          done_cyc0 = 0, done_n0 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int hex_val(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - int'("0");
      if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
      if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
      return -1;
   endfunction

   function automatic bit is_sep(input logic [7:0] c);
      return c == 8'h20 || c == 8'h2C || c == 8'h0D || c == 8'h0A || c == 8'h5B || c == 8'h5D;
   endfunction

   function automatic void model_step(input int i);
      int v;
      v = hex_val(s_rxb);
      if (rst) begin
         m_ph[i] = P_IDLE; m_hi[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0; m_addr[i] = 0; m_wd[i] = 0;
         return;
      end
      case (m_ph[i])
         P_IDLE: if (s_start) begin m_ph[i] = P_HI; m_cnt[i] = 0; m_err[i] = 1'b0; end
         P_HI: begin
            if (s_rerr) m_err[i] = 1'b1;
            else if (s_rxv && v >= 0) begin m_hi[i] = v; m_ph[i] = P_LO; end
            else if (s_rxv && !is_sep(s_rxb)) m_err[i] = 1'b1;
         end
         P_LO: begin
            if (s_rerr) m_err[i] = 1'b1;
            else if (s_rxv && v >= 0) begin
               m_addr[i] = (BASE + m_cnt[i]) % 2048;
               m_wd[i]   = m_hi[i] * 16 + v;
               m_ph[i]   = P_WR;
            end else if (s_rxv) begin
               m_err[i] = 1'b1; m_ph[i] = P_HI;
            end
         end
         P_WR: begin
            if (s_rerr || s_rxv) m_err[i] = 1'b1;
            m_mem[i][m_addr[i]] = 8'(m_wd[i]);
            m_cnt[i]++;
            m_ph[i] = (m_cnt[i] == nb[i]) ? P_FIN : P_HI;
         end
         default: begin
            if (s_rerr) m_err[i] = 1'b1;
            m_ph[i] = P_IDLE;
         end
      endcase
   endfunction

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   task automatic cmp(input int i, input logic en, input logic we, input logic [10:0] a,
                      input logic [7:0] d, input logic bz, input logic dn, input logic er,
                      input logic [5:0] bc);
      string p;
      p = $sformatf("cyc%0d dut%0d ", cyc, i);
      check({p, "sram_en"},    32'(en), 32'(m_ph[i] == P_WR));
      check({p, "sram_we"},    32'(we), 32'(m_ph[i] == P_WR));
      check({p, "sram_addr"},  32'(a),  32'(m_addr[i]));
      check({p, "sram_wdata"}, 32'(d),  32'(m_wd[i]));
      check({p, "busy"},       32'(bz), 32'(m_ph[i] == P_HI || m_ph[i] == P_LO || m_ph[i] == P_WR));
      check({p, "done"},       32'(dn), 32'(m_ph[i] == P_FIN));
      check({p, "err"},        32'(er), 32'(m_err[i]));
      check({p, "byte_count"}, 32'(bc), 32'(m_cnt[i]));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp(0, bus0.sram_en, bus0.sram_we, bus0.sram_addr, bus0.sram_wdata,
             bus0.busy, bus0.done, bus0.err, bus0.byte_count);
         cmp(1, bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_wdata,
             bus1.busy, bus1.done, bus1.err, bus1.byte_count);
         if (bus0.sram_en && bus0.sram_we) begin
            wlog0.push_back({bus0.sram_addr, bus0.sram_wdata});
            wcyc0.push_back(cyc);
            obs_mem[0][bus0.sram_addr] = bus0.sram_wdata;
         end
         if (bus1.sram_en && bus1.sram_we) begin
            wlog1.push_back({bus1.sram_addr, bus1.sram_wdata});
            obs_mem[1][bus1.sram_addr] = bus1.sram_wdata;
         end
         if (bus0.done) begin
            done_n0++;
            done_cyc0 = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; s_start = 1'b0; s_rxv = 1'b0; s_rerr = 1'b0;
      tick();
      rst = 1'b0;
      chk_on = 1'b1;
      wlog0.delete(); wlog1.delete(); wcyc0.delete();
      done_n0 = 0; done_cyc0 = 0;
   endtask

   task automatic pulse_start();
      s_start = 1'b1; tick(); s_start = 1'b0; tick();
   endtask

   task automatic send_char(input logic [7:0] c);
      s_rxv = 1'b1; s_rxb = c; tick(); s_rxv = 1'b0;
      repeat (1 + $urandom_range(0, 2)) tick();
   endtask

   task automatic send_str(input string s);
      for (int k = 0; k < s.len(); k++) send_char(s[k]);
   endtask

   function automatic logic [7:0] pick_char();
      string hx;
      int    r;
      hx = "0123456789abcdefABCDEF";
      r  = $urandom_range(0, 19);
      if (r < 14) return hx[$urandom_range(0, 21)];
      case (r)
         14: return 8'h20;
         15: return 8'h2C;
         16: return 8'h0D;
         17: return 8'h0A;
         18: return ($urandom_range(0, 1) != 0) ? 8'h5B : 8'h5D;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int mism;
      foreach (m_mem[i, a]) begin
         m_mem[i][a] = 8'h00; obs_mem[i][a] = 8'h00;
      end

      // Two-byte frame: addresses 2 and 3, done one cycle after the second write.
      do_reset();
      pulse_start();
      send_str("1f,A0");
      repeat (4) tick();
      @(negedge clk);
      check("s1 write count", wlog0.size(), 2);
      check("s1 write0", (wlog0.size() > 0) ? wlog0[0] : 19'h7FFFF, {11'd2, 8'h1F});
      check("s1 write1", (wlog0.size() > 1) ? wlog0[1] : 19'h7FFFF, {11'd3, 8'hA0});
      check("s1 done latency", done_cyc0, (wcyc0.size() > 1) ? wcyc0[1] + 1 : -1);
      check("s1 done pulses", done_n0, 1);
      check("s1 err", bus0.err, 0);
      check("s1 byte_count", bus0.byte_count, 2);
      check("s1 busy after done", bus0.busy, 0);

      // Separators around a digit pair.
      do_reset();
      pulse_start();
      send_str("[ ");
      send_char(8'h0D); send_char(8'h0A);
      send_str("0c");
      send_char(8'h0D); send_char(8'h0A);
      send_str(" ]");
      @(negedge clk);
      check("s2 write count", wlog1.size(), 1);
      check("s2 write0", (wlog1.size() > 0) ? wlog1[0] : 19'h7FFFF, {11'd2, 8'h0C});
      check("s2 err", bus1.err, 0);

      // Bad low digit, then a good pair.
      do_reset();
      pulse_start();
      send_str("3G");
      @(negedge clk);
      check("s3 err after G", bus1.err, 1);
      check("s3 no write", wlog1.size(), 0);
      check("s3 busy", bus1.busy, 1);
      send_str("45");
      @(negedge clk);
      check("s3 write0", (wlog1.size() > 0) ? wlog1[0] : 19'h7FFFF, {11'd2, 8'h45});

      // Character forced into the WRITE cycle.
      do_reset();
      pulse_start();
      send_char("1");
      s_rxv = 1'b1; s_rxb = "2"; tick();
      s_rxb = "7"; tick();
      s_rxv = 1'b0; tick();
      @(negedge clk);
      check("s4 overrun err", bus1.err, 1);
      send_str("34");
      @(negedge clk);
      check("s4 write count", wlog1.size(), 2);
      check("s4 write1", (wlog1.size() > 1) ? wlog1[1] : 19'h7FFFF, {11'd3, 8'h34});
      check("s4 byte_count", bus1.byte_count, 2);

      // Reset mid-frame after five bytes.
      do_reset();
      pulse_start();
      send_str("0102030405");
      send_char("6");
      @(negedge clk);
      check("s5 count before rst", bus1.byte_count, 5);
      rst = 1'b1; s_start = 1'b1; s_rxv = 1'b1; s_rxb = "7"; s_rerr = 1'b1;
      tick();
      rst = 1'b0; s_start = 1'b0; s_rxv = 1'b0; s_rerr = 1'b0;
      @(negedge clk);
      check("s5 rst outputs", {bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_wdata,
                               bus1.busy, bus1.done, bus1.err, bus1.byte_count}, 0);
      pulse_start();
      send_str("AA");
      @(negedge clk);
      check("s5 reload write", (wlog1.size() > 0) ? wlog1[wlog1.size() - 1] : 19'h7FFFF, {11'd2, 8'hAA});
      check("s5 kept byte 6", obs_mem[1][6], 8'h05);
      check("s5 kept byte 3", obs_mem[1][3], 8'h02);

      // Start while busy, and recv_error together with rx_valid.
      do_reset();
      pulse_start();
      send_char("5");
      s_start = 1'b1; s_rerr = 1'b1; s_rxv = 1'b1; s_rxb = "6"; tick();
      s_start = 1'b0; s_rerr = 1'b0; s_rxv = 1'b0; tick();
      @(negedge clk);
      check("s6 err", bus1.err, 1);
      check("s6 byte_count", bus1.byte_count, 0);
      check("s6 busy", bus1.busy, 1);
      send_char("7");
      @(negedge clk);
      check("s6 write0", (wlog1.size() > 0) ? wlog1[0] : 19'h7FFFF, {11'd2, 8'h57});
      check("s6 err kept", bus1.err, 1);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rst     = ($urandom_range(0, 299) == 0);
         s_start = ($urandom_range(0, 15) == 0);
         s_rxv   = ($urandom_range(0, 2) == 0);
         s_rxb   = pick_char();
         s_rerr  = ($urandom_range(0, 39) == 0);
         tick();
      end
      rst = 1'b0; s_start = 1'b0; s_rxv = 1'b0; s_rerr = 1'b0;
      repeat (3) tick();
      @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         mism = 0;
         for (int a = 0; a < 2048; a++)
            if (obs_mem[i][a] !== m_mem[i][a]) mism++;
         check($sformatf("mem image dut%0d", i), mism, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
